ram_2w2r_xor: RTL and testbench

- Parametrised successor to the cache valid/tag 2-write/1-read XOR memory: 2 independent write ports, 2 independent read ports, any width and depth.
- Each write port owns one XOR bank, replicated once per reader: 1 copy for the other writer's old-value lookup and 1 copy per read port. Every replica is a 1R1W block RAM.
- Adds synchronous reset and a bulk-clear sweep, so caches can invalidate all lines without external address sequencing.

---
 rtl/ram_2w2r_xor.sv | 204 ++++++++++++++++++++
 tb/tb_ram_2w2r_xor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_2w2r_xor.sv
// Two-write / two-read memory built from 1R1W replicas using the XOR-bank scheme:
// word X = bank_a[X] ^ bank_b[X]. Includes a synchronous bulk-clear sweep.
module ram_2w2r_xor #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en_a,
    input  logic [ADDR_W-1:0] w_addr_a,
    input  logic [WIDTH-1:0]  w_data_a,
    input  logic              w_en_b,
    input  logic [ADDR_W-1:0] w_addr_b,
    input  logic [WIDTH-1:0]  w_data_b,
    input  logic              r_en_a,
    input  logic [ADDR_W-1:0] r_addr_a,
    output logic [WIDTH-1:0]  r_data_a,
    input  logic              r_en_b,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [WIDTH-1:0]  r_data_b,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // Replica 0 serves the other writer's old-value lookup, 1 and 2 serve read ports A and B.
    localparam int unsigned NREP  = 3;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nx;
    logic [ADDR_W:0] cnt, cnt_nx;

    logic [WIDTH-1:0] bank_a [NREP][DEPTH];
    logic [WIDTH-1:0] bank_b [NREP][DEPTH];

    logic              clr_go, acc_a, acc_b, act_a, act_b;
    logic              p1_a_vld, p1_b_vld;
    logic [ADDR_W-1:0] p1_a_addr, p1_b_addr;
    logic [WIDTH-1:0]  p1_a_data, p1_b_data;
    logic [WIDTH-1:0]  lk_a, lk_b;
    logic              fa_hit, fb_hit;
    logic [WIDTH-1:0]  fa_word, fb_word;
    logic [WIDTH-1:0]  old_a, old_b, word_a, word_b;
    logic              we_a, we_b;
    logic [ADDR_W-1:0] wad_a, wad_b;
    logic [WIDTH-1:0]  wdat_a, wdat_b;

    logic              r_en_v   [2];
    logic [ADDR_W-1:0] r_addr_v [2];
    logic              fhit     [2];
    logic [WIDTH-1:0]  fval     [2];
    logic              rf_hit   [2];
    logic [WIDTH-1:0]  rf_val   [2];
    logic [WIDTH-1:0]  rq_a     [2];
    logic [WIDTH-1:0]  rq_b     [2];

    assign busy = (state == CLEAR);

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- write pipeline ----------------
    assign clr_go = (state == IDLE) && clr_req;
    assign acc_a  = w_en_a && (state == IDLE) && !clr_req;
    assign acc_b  = w_en_b && (state == IDLE) && !clr_req && !(acc_a && (w_addr_a == w_addr_b));
    assign act_a  = p1_a_vld && !clr_go;
    assign act_b  = p1_b_vld && !clr_go;

    // The lookup RAM reads old data when the other bank writes the same word that cycle,
    // so the other bank's just-written word is captured and substituted.
    assign old_a  = fa_hit ? fa_word : lk_b;
    assign old_b  = fb_hit ? fb_word : lk_a;
    assign word_a = p1_a_data ^ old_a;
    assign word_b = p1_b_data ^ old_b;

    assign we_a   = busy || act_a;
    assign we_b   = busy || act_b;
    assign wad_a  = busy ? cnt[ADDR_W-1:0] : p1_a_addr;
    assign wad_b  = busy ? cnt[ADDR_W-1:0] : p1_b_addr;
    assign wdat_a = busy ? '0 : word_a;
    assign wdat_b = busy ? '0 : word_b;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREP; i++) begin
            if (we_a) bank_a[i][wad_a] <= wdat_a;
            if (we_b) bank_b[i][wad_b] <= wdat_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_a_vld  <= 1'b0;
            p1_a_addr <= '0;
            p1_a_data <= '0;
            p1_b_vld  <= 1'b0;
            p1_b_addr <= '0;
            p1_b_data <= '0;
            lk_a      <= '0;
            lk_b      <= '0;
            fa_hit    <= 1'b0;
            fa_word   <= '0;
            fb_hit    <= 1'b0;
            fb_word   <= '0;
        end else begin
            p1_a_vld  <= acc_a;
            p1_a_addr <= w_addr_a;
            p1_a_data <= w_data_a;
            p1_b_vld  <= acc_b;
            p1_b_addr <= w_addr_b;
            p1_b_data <= w_data_b;
            lk_b      <= bank_b[0][w_addr_a];
            lk_a      <= bank_a[0][w_addr_b];
            fa_hit    <= act_b && (p1_b_addr == w_addr_a);
            fa_word   <= word_b;
            fb_hit    <= act_a && (p1_a_addr == w_addr_b);
            fb_word   <= word_a;
        end
    end

    // ---------------- read ports ----------------
    assign r_en_v[0]   = r_en_a;
    assign r_en_v[1]   = r_en_b;
    assign r_addr_v[0] = r_addr_a;
    assign r_addr_v[1] = r_addr_b;

    // Newest source first: writes presented this cycle, then writes landing in RAM this cycle.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            fhit[p] = 1'b0;
            fval[p] = '0;
            if (busy) begin
                fhit[p] = 1'b1;
            end else if (acc_a && (w_addr_a == r_addr_v[p])) begin
                fhit[p] = 1'b1;
                fval[p] = w_data_a;
            end else if (acc_b && (w_addr_b == r_addr_v[p])) begin
                fhit[p] = 1'b1;
                fval[p] = w_data_b;
            end else if (act_a && (p1_a_addr == r_addr_v[p])) begin
                fhit[p] = 1'b1;
                fval[p] = p1_a_data;
            end else if (act_b && (p1_b_addr == r_addr_v[p])) begin
                fhit[p] = 1'b1;
                fval[p] = p1_b_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < 2; p++) begin
                rf_hit[p] <= 1'b0;
                rf_val[p] <= '0;
                rq_a[p]   <= '0;
                rq_b[p]   <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (r_en_v[p]) begin
                    rf_hit[p] <= fhit[p];
                    rf_val[p] <= fval[p];
                    rq_a[p]   <= bank_a[p + 1][r_addr_v[p]];
                    rq_b[p]   <= bank_b[p + 1][r_addr_v[p]];
                end
            end
        end
    end

    assign r_data_a = rf_hit[0] ? rf_val[0] : (rq_a[0] ^ rq_b[0]);
    assign r_data_b = rf_hit[1] ? rf_val[1] : (rq_a[1] ^ rq_b[1]);

endmodule

// File: tb/tb_ram_2w2r_xor.sv
// Directed bench for ram_2w2r_xor: expected read data is queued at issue time and
// checked by an independent monitor one cycle later.
module tb_ram_2w2r_xor;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en_a, w_en_b, r_en_a, r_en_b, clr_req;
    logic [3:0] w_addr_a, w_addr_b, r_addr_a, r_addr_b;
    logic [7:0] w_data_a, w_data_b;
    logic [7:0] r_data_a, r_data_b;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       pend_a = 1'b0;
    logic       pend_b = 1'b0;

    always #5 clk = ~clk;

    ram_2w2r_xor #(.WIDTH(8), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .w_en_a(w_en_a), .w_addr_a(w_addr_a), .w_data_a(w_data_a),
        .w_en_b(w_en_b), .w_addr_b(w_addr_b), .w_data_b(w_data_b),
        .r_en_a(r_en_a), .r_addr_a(r_addr_a), .r_data_a(r_data_a),
        .r_en_b(r_en_b), .r_addr_b(r_addr_b), .r_data_b(r_data_b),
        .clr_req(clr_req), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read issued before a posedge is checked at the following negedge.
    always @(posedge clk) begin
        pend_a <= r_en_a;
        pend_b <= r_en_b;
    end

    always @(negedge clk) begin
        if (pend_a) begin
            if (qa.size() == 0) chk("rd_a_unexpected", 32'd1, 32'd0);
            else chk("rd_a", {24'd0, r_data_a}, {24'd0, qa.pop_front()});
        end
        if (pend_b) begin
            if (qb.size() == 0) chk("rd_b_unexpected", 32'd1, 32'd0);
            else chk("rd_b", {24'd0, r_data_b}, {24'd0, qb.pop_front()});
        end
    end

    task automatic idle_inputs();
        w_en_a = 1'b0; w_addr_a = '0; w_data_a = '0;
        w_en_b = 1'b0; w_addr_b = '0; w_data_b = '0;
        r_en_a = 1'b0; r_addr_a = '0;
        r_en_b = 1'b0; r_addr_b = '0;
        clr_req = 1'b0;
    endtask

    // One clock cycle of stimulus, entered and left at a negedge.
    task automatic cyc(input logic wae, input logic [3:0] waa, input logic [7:0] wad,
                       input logic wbe, input logic [3:0] wba, input logic [7:0] wbd,
                       input logic rae, input logic [3:0] raa, input logic [7:0] exa,
                       input logic rbe, input logic [3:0] rba, input logic [7:0] exb,
                       input logic clr);
        w_en_a = wae; w_addr_a = waa; w_data_a = wad;
        w_en_b = wbe; w_addr_b = wba; w_data_b = wbd;
        r_en_a = rae; r_addr_a = raa;
        r_en_b = rbe; r_addr_b = rba;
        clr_req = clr;
        if (rae) qa.push_back(exa);
        if (rbe) qb.push_back(exb);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Counts negedges with busy high; optionally pokes a read and a stray clr_req mid-sweep.
    task automatic count_busy(input int stop_at, input bit inject, output int n);
        n = 0;
        while (busy && n < 64 && n != stop_at) begin
            clr_req  = inject && (n == 5);
            r_en_a   = inject && (n == 3);
            r_addr_a = 4'd2;
            if (inject && n == 3) qa.push_back(8'h00);
            n++;
            @(negedge clk);
        end
        clr_req = 1'b0;
        r_en_a  = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 0, 0, 0, 1, 4'(i), 8'h00, 1, 4'(15 - i), 8'h00, 0);
        nop(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset state and power-on sweep length
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rda", {24'd0, r_data_a}, 32'd0);
        chk("reset_rdb", {24'd0, r_data_b}, 32'd0);
        count_busy(-1, 1'b0, n);
        chk("init_sweep_len", n, 32'd16);
        read_all_zero();

        // Consecutive writes to the same word on different ports
        cyc(1, 4'd3, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4'd3, 8'hC3, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd3, 8'hC3, 1, 4'd3, 8'hC3, 0);
        nop(1);
        chk("hold_a", {24'd0, r_data_a}, 32'h0000_00C3);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd3, 8'hC3, 1, 4'd3, 8'hC3, 0);

        // Same-address collision: port A wins, B is dropped
        cyc(1, 4'd7, 8'h11, 1, 4'd7, 8'h22, 1, 4'd7, 8'h11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd7, 8'h11, 1, 4'd7, 8'h11, 0);
        nop(2);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd7, 8'h11, 1, 4'd7, 8'h11, 0);

        // Write-first read in the same cycle on both ports
        cyc(1, 4'd5, 8'hF0, 0, 0, 0, 1, 4'd5, 8'hF0, 1, 4'd5, 8'hF0, 0);
        nop(2);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd5, 8'hF0, 1, 4'd5, 8'hF0, 0);

        // Reads one and two cycles after a write
        cyc(0, 0, 0, 1, 4'd9, 8'h77, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd9, 8'h77, 0, 0, 0, 0);
        cyc(1, 4'd10, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd10, 8'h3C, 0);

        // B then A to the same word, and back-to-back writes on one port
        cyc(0, 0, 0, 1, 4'd12, 8'h0F, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4'd12, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4'd13, 8'h01, 0, 0, 0, 1, 4'd12, 8'hF0, 1, 4'd12, 8'hF0, 0);
        cyc(1, 4'd13, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(2);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd12, 8'hF0, 1, 4'd13, 8'h02, 0);

        // Fill all words with addr+1, read back, then clear with a write in the clr cycle
        for (int i = 0; i < 8; i++)
            cyc(1, 4'(2 * i), 8'(2 * i + 1), 1, 4'(2 * i + 1), 8'(2 * i + 2), 0, 0, 0, 0, 0, 0, 0);
        nop(2);
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 0, 0, 0, 1, 4'(i), 8'(i + 1), 1, 4'(15 - i), 8'(16 - i), 0);
        cyc(1, 4'd2, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_busy_rise", {31'd0, busy}, 32'd1);
        count_busy(-1, 1'b1, n);
        chk("clr_sweep_len", n, 32'd16);
        chk("clr_busy_fall", {31'd0, busy}, 32'd0);
        read_all_zero();

        // Reset in the middle of a sweep restarts it
        cyc(1, 4'd4, 8'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd4, 8'h44, 1, 4'd4, 8'h44, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        count_busy(9, 1'b0, n);
        chk("pre_rst_count", n, 32'd9);
        chk("pre_rst_hold_a", {24'd0, r_data_a}, 32'h0000_0044);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rda", {24'd0, r_data_a}, 32'd0);
        chk("rst_mid_rdb", {24'd0, r_data_b}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        count_busy(-1, 1'b0, n);
        chk("restart_sweep_len", n, 32'd16);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd4, 8'h00, 1, 4'd4, 8'h00, 0);
        cyc(0, 0, 0, 1, 4'd4, 8'h5E, 0, 0, 0, 0, 0, 0, 0);
        nop(2);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd4, 8'h5E, 1, 4'd4, 8'h5E, 0);
        nop(3);

        chk("queue_a_drained", qa.size(), 32'd0);
        chk("queue_b_drained", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
